// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Packs the remainder into the upper half of result_o and the quotient into the lower half.
// Operands are captured once when leaving FREE; signs are corrected after the last iteration.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_FREE   = 2'b00,
        ST_BYZERO = 2'b01,
        ST_ON     = 2'b10,
        ST_END    = 2'b11
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH:0]   dividend_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic               sign1_reg;
    logic               sign2_reg;
    logic               signed_reg;

    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quot_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quot_fin;
    logic [WIDTH-1:0]   rem_fin;
    logic               accept;

    // Magnitudes of the incoming operands, trial subtraction and sign-corrected results
    always_comb begin
        abs1     = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2     = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        diff     = dividend_reg[2*WIDTH:WIDTH] - {1'b0, divisor_reg};
        quot_raw = dividend_reg[WIDTH-1:0];
        rem_raw  = dividend_reg[2*WIDTH:WIDTH+1];
        quot_fin = (signed_reg && (sign1_reg != sign2_reg)) ? -quot_raw : quot_raw;
        rem_fin  = (signed_reg && sign1_reg) ? -rem_raw : rem_raw;
        accept   = start_i && !annul_i;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FREE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FREE: begin
                if (accept) begin
                    state_next = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: begin
                state_next = annul_i ? ST_FREE : ST_END;
            end
            ST_ON: begin
                if (annul_i) begin
                    state_next = ST_FREE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_END;
                end
            end
            ST_END: begin
                state_next = start_i ? ST_END : ST_FREE;
            end
            default: state_next = ST_FREE;
        endcase
    end

    // Datapath iteration and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            sign1_reg    <= 1'b0;
            sign2_reg    <= 1'b0;
            signed_reg   <= 1'b0;
            result_o     <= '0;
            ready_o      <= 1'b0;
        end else begin
            case (state_reg)
                ST_FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (accept && (opdata2_i != '0)) begin
                        cnt_reg      <= '0;
                        dividend_reg <= {{WIDTH{1'b0}}, abs1, 1'b0};
                        divisor_reg  <= abs2;
                        sign1_reg    <= opdata1_i[WIDTH-1];
                        sign2_reg    <= opdata2_i[WIDTH-1];
                        signed_reg   <= signed_div_i;
                    end
                end
                ST_BYZERO: begin
                    if (!annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                ST_ON: begin
                    // An annulled division never exposes a partial result
                    if (!annul_i) begin
                        if (cnt_reg != CNT_LAST) begin
                            if (diff[WIDTH]) begin
                                dividend_reg <= {dividend_reg[2*WIDTH-1:0], 1'b0};
                            end else begin
                                dividend_reg <= {diff[WIDTH-1:0], dividend_reg[WIDTH-1:0], 1'b1};
                            end
                            cnt_reg <= cnt_reg + 1'b1;
                        end else begin
                            result_o <= {rem_fin, quot_fin};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                ST_END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, annul, async reset,
// and randomized signed/unsigned divisions against a plain-arithmetic reference.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int failures = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    // Reference: {remainder, quotient} from 64-bit integer arithmetic (truncating division)
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction: hold start until ready, check latency/result, then release
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int          edges;
        bit          leak;
        exp        = ref_div(s, a, b);
        signed_div = s;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        edges      = 0;
        leak       = 1'b0;
        while (edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                // Operands are captured already; these must have no effect
                op1        = $urandom;
                op2        = $urandom;
                signed_div = 1'($urandom);
            end
            if (ready) break;
            if (result !== 64'd0) leak = 1'b1;
        end
        check({tag, " latency"}, 64'(edges), (b == 32'd0) ? 64'd2 : 64'd34);
        check({tag, " result"}, result, exp);
        check({tag, " no_early_result"}, 64'(leak), 64'd0);
        $display("div %s s=%0d a=%h b=%h -> result=%h edges=%0d", tag, s, a, b, result, edges);
        @(posedge clk); #1;
        check({tag, " held_in_end"}, {63'd0, ready}, 64'd1);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready_cleared"}, {63'd0, ready}, 64'd0);
        check({tag, " result_cleared"}, result, 64'd0);
    endtask

    initial begin
        bit          seen;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        rst        = 1'b1;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;
        #1;
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset result", result, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle ready", {63'd0, ready}, 64'd0);

        // Directed cases
        run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
        check("divu_100_7 literal", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
        run_div(1'b0, 32'd1234, 32'd0, "divu_by_zero");
        run_div(1'b1, 32'h8000_0000, 32'd0, "div_by_zero");
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big_small");

        // Annul in the middle of an iteration sequence
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        check("annul no_ready", {63'd0, seen}, 64'd0);
        check("annul result", result, 64'd0);
        $display("annul mid-ON: ready_seen=%0d", seen);
        run_div(1'b0, 32'd50, 32'd5, "after_annul_50_5");

        // Asynchronous reset mid-ON, then a clean operation
        signed_div = 1'b1;
        op1        = 32'd99999;
        op2        = 32'd13;
        start      = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("rst_mid_on ready", {63'd0, ready}, 64'd0);
        check("rst_mid_on result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-ON: ready=%0d result=%h", ready, result);
        run_div(1'b1, 32'hFFFF_FF00, 32'd16, "after_rst");

        // Asynchronous reset while a result is being presented
        signed_div = 1'b0;
        op1        = 32'd100;
        op2        = 32'd7;
        start      = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("end_rst reached_ready", {63'd0, seen}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_in_end ready", {63'd0, ready}, 64'd0);
        check("rst_in_end result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("reset in END: ready=%0d result=%h", ready, result);

        // Randomized mix of signed and unsigned divisions
        for (int n = 0; n < 24; n++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case (n % 4)
                0: rb = $urandom;
                1: rb = 32'($urandom_range(255, 1));
                2: rb = (n % 8 == 2) ? 32'd0 : -32'($urandom_range(100, 1));
                default: rb = ra >> $urandom_range(31, 1);
            endcase
            run_div(rs, ra, rb, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
